// File: rtl/adder_tree_fold_ctrl.sv
// Folded signed reduction: one pairwise adder layer reused over log2(N) passes.
// Optional accumulator on the result path enabled by defining ADDER_FOLD_ACC_EN.

module adder_tree_layer_signed #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int DATAW         = 8
) (
  input  logic signed [DATAW-1:0] data_i [INPUTS_AMOUNT],
  output logic signed [DATAW:0]   data_o [INPUTS_AMOUNT/2]
);
  genvar gi;
  generate
    for (gi = 0; gi < INPUTS_AMOUNT / 2; gi++) begin : g_pair
      assign data_o[gi] = (DATAW+1)'(data_i[2*gi]) + (DATAW+1)'(data_i[2*gi+1]);
    end
  endgenerate
endmodule

module adder_tree_fold_ctrl #(
  parameter  int N     = 8,
  parameter  int DATAW = 8,
  localparam int P     = $clog2(N),
  localparam int OUTW  = DATAW + $clog2(N),
`ifdef ADDER_FOLD_ACC_EN
  localparam int RESW  = OUTW + 8
`else
  localparam int RESW  = OUTW
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [DATAW-1:0] in_data_i [N],
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [RESW-1:0]  out_data_o,
  output logic                    busy_o
`ifdef ADDER_FOLD_ACC_EN
  ,
  input  logic                    acc_clr_i
`endif
);
  localparam int CNTW = $clog2(P + 1);

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [OUTW-1:0]  r_q [N];
  logic signed [OUTW-1:0]  r_d [N];
  logic [CNTW-1:0]         pass_cnt_q, pass_cnt_d;
  logic signed [OUTW:0]    layer_out [N/2];
  logic                    last_pass;
  logic                    accept;

  adder_tree_layer_signed #(
    .INPUTS_AMOUNT (N),
    .DATAW         (OUTW)
  ) u_layer (
    .data_i (r_q),
    .data_o (layer_out)
  );

  assign last_pass = (pass_cnt_q == CNTW'(P - 1));
  assign accept    = (state_q == IDLE) && in_valid_i;

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          for (int i = 0; i < N; i++) r_d[i] = OUTW'(in_data_i[i]);
          pass_cnt_d = '0;
          state_d    = REDUCE;
        end
      end
      REDUCE: begin
        // Sums never exceed OUTW bits, so dropping the carry bit is lossless.
        for (int i = 0; i < N / 2; i++) r_d[i] = OUTW'(layer_out[i]);
        for (int i = N / 2; i < N; i++) r_d[i] = '0;
        pass_cnt_d = pass_cnt_q + 1'b1;
        if (last_pass) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pass_cnt_q <= '0;
      for (int i = 0; i < N; i++) r_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
      r_q        <= r_d;
    end
  end

`ifdef ADDER_FOLD_ACC_EN
  logic signed [RESW-1:0] acc_q, acc_d;
  logic                   acc_clr_q, acc_clr_d;

  always_comb begin
    acc_d     = acc_q;
    acc_clr_d = acc_clr_q;
    if (accept) acc_clr_d = acc_clr_i;
    if (state_q == REDUCE && last_pass)
      acc_d = (acc_clr_q ? RESW'(0) : acc_q) + RESW'(r_d[0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      acc_clr_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_clr_q <= acc_clr_d;
    end
  end

  assign out_data_o = (state_q == DONE) ? acc_q : '0;
`else
  assign out_data_o = (state_q == DONE) ? r_q[0] : '0;
`endif

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == REDUCE) || (state_q == DONE);
endmodule
